// File: rtl/parser_in_arbiter.sv
// parser_in_arbiter
// -----------------
// Packet-granular round-robin arbiter that shares one parser between
// NUM_PORTS AXI-Stream ingress ports. The parser has no backpressure and
// detects a new packet on a rising edge of tvalid. For that reason a grant
// is held for a whole packet, and every packet is followed by a guaranteed
// idle gap on the output.
//
// Output timing, with the tlast beat accepted in cycle T:
//   - that last beat is on m_axis in T+1.
//   - GAP occupies T+1..T+GAP_CYCLES. IDLE re-arbitrates in T+GAP_CYCLES+1.
//   - the next first beat appears on m_axis in T+GAP_CYCLES+3.
//   - so m_axis_tvalid is low for exactly GAP_CYCLES+1 cycles between packets.
//
// Handshake: a beat moves on port i when s_axis_tvalid[i] & s_axis_tready[i]
// are both high at a rising clock edge. s_axis_tready is combinational from
// the FSM state and the grant only, never from tvalid. m_axis has no ready:
// every cycle with m_axis_tvalid=1 is a beat. The other m_axis fields hold
// their previous values while tvalid is low.
//
// Optional feature (macro PARSER_ARB_SRC_TAG_EN): the top 3 tuser bits of
// every forwarded beat are replaced by the granted port index.
//
// Ports:
//   axis_clk, areset             clock, asynchronous active-high reset
//   s_axis_t{data,user,keep}     packed per-port inputs, port i = slice i
//   s_axis_t{valid,last,ready}   per-port handshake
//   m_axis_t*                    registered stream to the parser (no ready)
//   grant_oh                     one-hot owner while a packet is in flight
//   err_bubble                   sticky: owner dropped tvalid mid-packet
module parser_in_arbiter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS            = 4,
  parameter int GAP_CYCLES           = 3
) (
  input  logic                                        axis_clk,
  input  logic                                        areset,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]                        s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                        s_axis_tlast,
  output logic [NUM_PORTS-1:0]                        s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]            m_axis_tkeep,
  output logic                                        m_axis_tvalid,
  output logic                                        m_axis_tlast,
  output logic [NUM_PORTS-1:0]                        grant_oh,
  output logic                                        err_bubble
);

  localparam int DW     = C_S_AXIS_DATA_WIDTH;
  localparam int UW     = C_S_AXIS_TUSER_WIDTH;
  localparam int KW     = C_S_AXIS_DATA_WIDTH / 8;
  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W  = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [CNT_W-1:0] gap_cnt;
  logic             first_done;

  logic             pick_vld;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] pick_nxt;
  logic             beat_acc;
  logic [DW-1:0]    sel_data;
  logic [UW-1:0]    sel_user;
  logic [KW-1:0]    sel_keep;
  logic             sel_last;

  // Round-robin pick: scan from rr_ptr upward with wrap. The loop runs from
  // the farthest offset down to offset 0, so the closest requester is the
  // last one to write pick_idx and therefore wins.
  always_comb begin
    int               j;
    logic [PTR_W-1:0] jj;
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = 0;
    jj       = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      jj = PTR_W'(j);
      if (s_axis_tvalid[jj]) begin
        pick_vld = 1'b1;
        pick_idx = jj;
      end
    end
  end

  // The port after the one just granted gets top priority next round.
  assign pick_nxt = (int'(pick_idx) == NUM_PORTS - 1) ? '0 : pick_idx + 1'b1;

  // Granted-port beat selection.
  assign beat_acc = (state == PASS) && s_axis_tvalid[gnt_idx];
  assign sel_data = s_axis_tdata[gnt_idx*DW +: DW];
  assign sel_keep = s_axis_tkeep[gnt_idx*KW +: KW];
  assign sel_last = s_axis_tlast[gnt_idx];

  always_comb begin
    sel_user = s_axis_tuser[gnt_idx*UW +: UW];
`ifdef PARSER_ARB_SRC_TAG_EN
    sel_user[UW-1 -: 3] = 3'(gnt_idx);
`else
`endif
  end

  // FSM state register.
  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and ready decode.
  always_comb begin
    state_nxt     = state;
    s_axis_tready = '0;
    case (state)
      IDLE: if (pick_vld) state_nxt = PASS;
      PASS: begin
        s_axis_tready[gnt_idx] = 1'b1;
        if (beat_acc && sel_last) state_nxt = GAP;
      end
      GAP:  if (gap_cnt == CNT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration bookkeeping and the registered output stage.
  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      rr_ptr        <= '0;
      gnt_idx       <= '0;
      gap_cnt       <= '0;
      first_done    <= 1'b0;
      grant_oh      <= '0;
      err_bubble    <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      m_axis_tvalid <= beat_acc;
      if (beat_acc) begin
        m_axis_tdata <= sel_data;
        m_axis_tuser <= sel_user;
        m_axis_tkeep <= sel_keep;
        m_axis_tlast <= sel_last;
      end
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt_idx    <= pick_idx;
            rr_ptr     <= pick_nxt;
            grant_oh   <= NUM_PORTS'(1) << pick_idx;
            first_done <= 1'b0;
          end
        end
        PASS: begin
          // A hole before the first beat is not a bubble: the packet has
          // not started yet from the parser's point of view.
          if (beat_acc)        first_done <= 1'b1;
          else if (first_done) err_bubble <= 1'b1;
          if (beat_acc && sel_last) begin
            gap_cnt  <= CNT_W'(GAP_CYCLES);
            grant_oh <= '0;
          end
        end
        GAP:     gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parser_in_arbiter.sv
// Directed bench for parser_in_arbiter (default parameters, 4 ports, gap 3).
// Each port has a beat queue {last, data[15:0]}. The driver presents the head
// beat and pops it after a handshake. A monitor records every m_axis beat
// together with its cycle number.
module tb_parser_in_arbiter;

  localparam int DW = 512;
  localparam int UW = 128;
  localparam int KW = DW / 8;
  localparam int NP = 4;

  logic             clk = 1'b0;
  logic             areset = 1'b1;
  logic [NP*DW-1:0] s_axis_tdata = '0;
  logic [NP*UW-1:0] s_axis_tuser = '0;
  logic [NP*KW-1:0] s_axis_tkeep = '1;
  logic [NP-1:0]    s_axis_tvalid = '0;
  logic [NP-1:0]    s_axis_tlast = '0;
  logic [NP-1:0]    s_axis_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic [UW-1:0]    m_axis_tuser;
  logic [KW-1:0]    m_axis_tkeep;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic [NP-1:0]    grant_oh;
  logic             err_bubble;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [16:0]   pq [NP][$];
  logic [NP-1:0] hold = '0;
  logic [NP-1:0] acc  = '0;

  logic [15:0]   got_data[$];
  int            got_cyc[$];
  logic [UW-1:0] got_user[$];

  parser_in_arbiter dut (
    .axis_clk      (clk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .grant_oh      (grant_oh),
    .err_bubble    (err_bubble)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // Handshake sampling at the stable mid-cycle point.
  always @(negedge clk) acc = s_axis_tvalid & s_axis_tready;

  // Port drivers.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int p = 0; p < NP; p++) begin
      if (acc[p] && pq[p].size() > 0) void'(pq[p].pop_front());
      if (pq[p].size() > 0 && !hold[p]) begin
        s_axis_tvalid[p]          = 1'b1;
        s_axis_tdata[p*DW +: 16]  = pq[p][0][15:0];
        s_axis_tlast[p]           = pq[p][0][16];
      end else begin
        s_axis_tvalid[p] = 1'b0;
        s_axis_tlast[p]  = 1'b0;
      end
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (m_axis_tvalid) begin
      got_data.push_back(m_axis_tdata[15:0]);
      got_cyc.push_back(cyc);
      got_user.push_back(m_axis_tuser);
    end
  end

  task automatic clear_all();
    for (int p = 0; p < NP; p++) pq[p].delete();
    hold = '0;
    got_data.delete();
    got_cyc.delete();
    got_user.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset = 1'b1;
    clear_all();
    repeat (3) @(negedge clk);
    clear_all();
    areset = 1'b0;
  endtask

  task automatic wait_beats(input int n, input string name);
    int budget;
    budget = 200;
    while (got_data.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    total++;
    if (got_data.size() < n) begin
      bad++;
      $display("FAIL %s timeout: beats got %0d need %0d", name, got_data.size(), n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    areset = 1'b1;
    #1;
    total++;
    if ({m_axis_tvalid, m_axis_tlast, s_axis_tready, grant_oh, err_bubble} !== 11'd0 ||
        m_axis_tdata !== '0 || m_axis_tuser !== '0 || m_axis_tkeep !== '0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b tready=%b grant=%b err=%b data=%h, need all zero",
               m_axis_tvalid, s_axis_tready, grant_oh, err_bubble, m_axis_tdata[15:0]);
    end
    do_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({m_axis_tvalid, s_axis_tready, grant_oh, err_bubble} !== 10'd0) begin
      bad++;
      $display("FAIL idle_after_reset: valid=%b tready=%b grant=%b err=%b, need zero",
               m_axis_tvalid, s_axis_tready, grant_oh, err_bubble);
    end
  endtask

  task automatic test_two_beat();
    do_reset();
    pq[1].push_back({1'b0, 16'h00A1});
    pq[1].push_back({1'b1, 16'h00A2});
    @(negedge clk);  // tvalid just rose, still IDLE
    total++;
    if (s_axis_tready !== 4'b0000) begin
      bad++; $display("FAIL two_beat_ready_idle: got %b need 0000", s_axis_tready);
    end
    @(negedge clk);  // PASS, A1 accepted
    total++;
    if (s_axis_tready !== 4'b0010 || grant_oh !== 4'b0010) begin
      bad++; $display("FAIL two_beat_grant: tready=%b grant=%b need 0010/0010", s_axis_tready, grant_oh);
    end
    @(negedge clk);  // A1 on output, A2 accepted
    total++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata[15:0] !== 16'h00A1 || m_axis_tlast !== 1'b0 ||
        grant_oh !== 4'b0010) begin
      bad++; $display("FAIL two_beat_b1: v=%b d=%h l=%b g=%b need 1/00a1/0/0010",
                      m_axis_tvalid, m_axis_tdata[15:0], m_axis_tlast, grant_oh);
    end
    @(negedge clk);  // A2 on output, GAP
    total++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata[15:0] !== 16'h00A2 || m_axis_tlast !== 1'b1 ||
        grant_oh !== 4'b0000 || s_axis_tready !== 4'b0000) begin
      bad++; $display("FAIL two_beat_b2: v=%b d=%h l=%b g=%b r=%b need 1/00a2/1/0000/0000",
                      m_axis_tvalid, m_axis_tdata[15:0], m_axis_tlast, grant_oh, s_axis_tready);
    end
    @(negedge clk);
    total++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata[15:0] !== 16'h00A2) begin
      bad++; $display("FAIL two_beat_hold: v=%b d=%h need 0/00a2", m_axis_tvalid, m_axis_tdata[15:0]);
    end
  endtask

  task automatic test_all_ports();
    do_reset();
    for (int p = 0; p < NP; p++) pq[p].push_back({1'b1, 16'h00B0 + 16'(p)});
    wait_beats(4, "all_ports");
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== 16'h00B0 + 16'(i)) begin
        bad++; $display("FAIL all_ports_order[%0d]: got %h need %h", i, got_data[i], 16'h00B0 + 16'(i));
      end
    end
    for (int i = 1; i < 4 && i < got_cyc.size(); i++) begin
      total++;
      if (got_cyc[i] - got_cyc[i-1] !== 5) begin
        bad++; $display("FAIL all_ports_spacing[%0d]: got %0d cycles need 5", i, got_cyc[i] - got_cyc[i-1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pq[2].push_back({1'b1, 16'h00C0});
    pq[2].push_back({1'b1, 16'h00C1});
    pq[3].push_back({1'b1, 16'h00D0});
    wait_beats(3, "back_to_back");
    if (got_data.size() >= 3) begin
      total++;
      if (got_data[0] !== 16'h00C0 || got_data[1] !== 16'h00D0 || got_data[2] !== 16'h00C1) begin
        bad++; $display("FAIL back_to_back_order: got %h %h %h need 00c0 00d0 00c1",
                        got_data[0], got_data[1], got_data[2]);
      end
    end
  endtask

  task automatic test_bubble();
    do_reset();
    pq[0].push_back({1'b0, 16'h00E1});
    pq[0].push_back({1'b0, 16'h00E2});
    pq[0].push_back({1'b1, 16'h00E3});
    @(negedge clk);  // IDLE
    @(negedge clk);  // PASS, E1 accepted
    hold[0] = 1'b1;
    @(negedge clk);  // E1 out, port 0 silent
    total++;
    if (m_axis_tdata[15:0] !== 16'h00E1 || err_bubble !== 1'b0) begin
      bad++; $display("FAIL bubble_first: d=%h err=%b need 00e1/0", m_axis_tdata[15:0], err_bubble);
    end
    hold[0] = 1'b0;
    @(negedge clk);
    total++;
    if (m_axis_tvalid !== 1'b0 || err_bubble !== 1'b1) begin
      bad++; $display("FAIL bubble_gap: v=%b err=%b need 0/1", m_axis_tvalid, err_bubble);
    end
    @(negedge clk);
    total++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata[15:0] !== 16'h00E2) begin
      bad++; $display("FAIL bubble_e2: v=%b d=%h need 1/00e2", m_axis_tvalid, m_axis_tdata[15:0]);
    end
    @(negedge clk);
    total++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata[15:0] !== 16'h00E3 || m_axis_tlast !== 1'b1) begin
      bad++; $display("FAIL bubble_e3: v=%b d=%h l=%b need 1/00e3/1",
                      m_axis_tvalid, m_axis_tdata[15:0], m_axis_tlast);
    end
    repeat (6) @(negedge clk);
    total++;
    if (err_bubble !== 1'b1) begin
      bad++; $display("FAIL bubble_sticky: err=%b need 1", err_bubble);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int i = 1; i <= 4; i++) pq[1].push_back({(i == 4), 16'h00F0 + 16'(i)});
    @(negedge clk);  // IDLE
    @(negedge clk);  // PASS, beat 1
    @(negedge clk);  // PASS, beat 2
    total++;
    if (s_axis_tready !== 4'b0010) begin
      bad++; $display("FAIL rst_mid_pre: tready=%b need 0010", s_axis_tready);
    end
    areset = 1'b1;
    #1;
    total++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 4'b0000 || grant_oh !== 4'b0000) begin
      bad++; $display("FAIL rst_mid_now: v=%b tready=%b grant=%b need 0/0000/0000",
                      m_axis_tvalid, s_axis_tready, grant_oh);
    end
    clear_all();
    pq[0].push_back({1'b1, 16'h00D0});
    pq[2].push_back({1'b1, 16'h00D2});
    repeat (2) @(negedge clk);
    got_data.delete();
    got_cyc.delete();
    got_user.delete();
    areset = 1'b0;
    wait_beats(2, "rst_mid_after");
    if (got_data.size() >= 2) begin
      total++;
      if (got_data[0] !== 16'h00D0 || got_data[1] !== 16'h00D2) begin
        bad++; $display("FAIL rst_mid_order: got %h %h need 00d0 00d2", got_data[0], got_data[1]);
      end
    end
  endtask

  task automatic test_src_tag();
    logic [UW-1:0] exp_user;
    do_reset();
`ifdef PARSER_ARB_SRC_TAG_EN
    s_axis_tuser[3*UW +: UW] = '0;
    exp_user = '0;
    exp_user[UW-1 -: 3] = 3'b011;
`else
    s_axis_tuser[3*UW +: UW] = {4'hE, 120'h0, 4'h1};
    exp_user = {4'hE, 120'h0, 4'h1};
`endif
    pq[3].push_back({1'b1, 16'h0033});
    wait_beats(1, "src_tag");
    if (got_user.size() >= 1) begin
      total++;
      if (got_user[0] !== exp_user) begin
        bad++; $display("FAIL src_tag_user: got %h need %h", got_user[0], exp_user);
      end
    end
    s_axis_tuser = '0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_two_beat();
    test_all_ports();
    test_back_to_back();
    test_bubble();
    test_reset_mid_packet();
    test_src_tag();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
